// File: rtl/memory_ram_arbiter.sv
// Shares one RAM port between instruction fetch (A) and load/store (B).
// B has fixed priority; a starvation counter forces an A grant after STARVE_LIM B wins.
module memory_ram_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        i_A_REQ,
  input  logic [31:0] i_A_ADDR,
  output logic        o_A_GNT,
  output logic        o_A_DONE,
  output logic [31:0] o_A_RDATA,
  input  logic        i_B_REQ,
  input  logic        i_B_WR,
  input  logic [31:0] i_B_ADDR,
  input  logic [31:0] i_B_WDATA,
  output logic        o_B_GNT,
  output logic        o_B_DONE,
  output logic [31:0] o_B_RDATA,
  output logic        o_X_RAM_CE,
  output logic        o_X_RAM_RD,
  output logic        o_X_RAM_WR,
  output logic [31:0] o_X_RAM_ADDR,
  output logic [31:0] o_X_RAM_DATA_WR,
  input  logic [31:0] i_X_RAM_DATA_RD,
  output logic        o_BUSY
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     state;
  logic       owner_b;
  logic       lat_wr;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;

  // RAM strobes and address are registered at the IDLE->ACCESS edge straight from
  // the winning request, so they appear in the same cycle as the grant pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= IDLE;
      owner_b         <= 1'b0;
      lat_wr          <= 1'b0;
      lat_cnt         <= 3'd0;
      starve_cnt      <= 4'd0;
      o_A_GNT         <= 1'b0;
      o_A_DONE        <= 1'b0;
      o_A_RDATA       <= 32'd0;
      o_B_GNT         <= 1'b0;
      o_B_DONE        <= 1'b0;
      o_B_RDATA       <= 32'd0;
      o_X_RAM_CE      <= 1'b0;
      o_X_RAM_RD      <= 1'b0;
      o_X_RAM_WR      <= 1'b0;
      o_X_RAM_ADDR    <= 32'd0;
      o_X_RAM_DATA_WR <= 32'd0;
      o_BUSY          <= 1'b0;
    end else begin
      o_A_GNT         <= 1'b0;
      o_B_GNT         <= 1'b0;
      o_A_DONE        <= 1'b0;
      o_B_DONE        <= 1'b0;
      o_X_RAM_CE      <= 1'b0;
      o_X_RAM_RD      <= 1'b0;
      o_X_RAM_WR      <= 1'b0;
      o_X_RAM_ADDR    <= 32'd0;
      o_X_RAM_DATA_WR <= 32'd0;
      case (state)
        IDLE: begin
          if (i_B_REQ && (!i_A_REQ || starve_cnt < 4'(STARVE_LIM))) begin
            owner_b         <= 1'b1;
            lat_wr          <= i_B_WR;
            o_B_GNT         <= 1'b1;
            o_X_RAM_CE      <= 1'b1;
            o_X_RAM_RD      <= !i_B_WR;
            o_X_RAM_WR      <= i_B_WR;
            o_X_RAM_ADDR    <= i_B_ADDR;
            o_X_RAM_DATA_WR <= i_B_WDATA;
            o_BUSY          <= 1'b1;
            state           <= ACCESS;
            // B can only win over a waiting A below the limit, so this never overflows it
            starve_cnt      <= i_A_REQ ? starve_cnt + 4'd1 : 4'd0;
          end else if (i_A_REQ) begin
            owner_b      <= 1'b0;
            lat_wr       <= 1'b0;
            o_A_GNT      <= 1'b1;
            o_X_RAM_CE   <= 1'b1;
            o_X_RAM_RD   <= 1'b1;
            o_X_RAM_ADDR <= i_A_ADDR;
            o_BUSY       <= 1'b1;
            state        <= ACCESS;
            starve_cnt   <= 4'd0;
          end else begin
            starve_cnt <= 4'd0;
          end
        end
        ACCESS: begin
          if (lat_wr) begin
            o_A_DONE <= !owner_b;
            o_B_DONE <= owner_b;
            state    <= RESP;
          end else begin
            lat_cnt <= 3'(RD_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            if (owner_b) o_B_RDATA <= i_X_RAM_DATA_RD;
            else         o_A_RDATA <= i_X_RAM_DATA_RD;
            o_A_DONE <= !owner_b;
            o_B_DONE <= owner_b;
            state    <= RESP;
          end
        end
        RESP: begin
          o_BUSY <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_ram_arbiter.sv
// Directed bench for memory_ram_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// both fed from the same stimulus; each test task checks the instance it targets.
module tb_memory_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req, b_wr;
  logic [31:0] a_addr, b_addr, b_wdata, ram_rd_data;

  logic        d1_a_gnt, d1_a_done, d1_b_gnt, d1_b_done, d1_ce, d1_rd, d1_wr, d1_busy;
  logic [31:0] d1_a_rdata, d1_b_rdata, d1_addr, d1_dwr;
  logic        d3_a_gnt, d3_a_done, d3_b_gnt, d3_b_done, d3_ce, d3_rd, d3_wr, d3_busy;
  logic [31:0] d3_a_rdata, d3_b_rdata, d3_addr, d3_dwr;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  memory_ram_arbiter #(.RD_LAT(1), .STARVE_LIM(4)) u_dut1 (
    .CLK(clk), .RST_N(rst_n),
    .i_A_REQ(a_req), .i_A_ADDR(a_addr),
    .o_A_GNT(d1_a_gnt), .o_A_DONE(d1_a_done), .o_A_RDATA(d1_a_rdata),
    .i_B_REQ(b_req), .i_B_WR(b_wr), .i_B_ADDR(b_addr), .i_B_WDATA(b_wdata),
    .o_B_GNT(d1_b_gnt), .o_B_DONE(d1_b_done), .o_B_RDATA(d1_b_rdata),
    .o_X_RAM_CE(d1_ce), .o_X_RAM_RD(d1_rd), .o_X_RAM_WR(d1_wr),
    .o_X_RAM_ADDR(d1_addr), .o_X_RAM_DATA_WR(d1_dwr),
    .i_X_RAM_DATA_RD(ram_rd_data), .o_BUSY(d1_busy)
  );

  memory_ram_arbiter #(.RD_LAT(3), .STARVE_LIM(4)) u_dut3 (
    .CLK(clk), .RST_N(rst_n),
    .i_A_REQ(a_req), .i_A_ADDR(a_addr),
    .o_A_GNT(d3_a_gnt), .o_A_DONE(d3_a_done), .o_A_RDATA(d3_a_rdata),
    .i_B_REQ(b_req), .i_B_WR(b_wr), .i_B_ADDR(b_addr), .i_B_WDATA(b_wdata),
    .o_B_GNT(d3_b_gnt), .o_B_DONE(d3_b_done), .o_B_RDATA(d3_b_rdata),
    .o_X_RAM_CE(d3_ce), .o_X_RAM_RD(d3_rd), .o_X_RAM_WR(d3_wr),
    .o_X_RAM_ADDR(d3_addr), .o_X_RAM_DATA_WR(d3_dwr),
    .i_X_RAM_DATA_RD(ram_rd_data), .o_BUSY(d3_busy)
  );

  // Each call lands 1 time unit after a rising edge: outputs settled, inputs safe to change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_wr = 1'b0;
    b_addr = '0; b_wdata = '0; ram_rd_data = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({d1_a_gnt, d1_a_done, d1_a_rdata, d1_b_gnt, d1_b_done, d1_b_rdata,
         d1_ce, d1_rd, d1_wr, d1_addr, d1_dwr, d1_busy} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs_lat1: some output nonzero (busy=%b ce=%b), required all 0",
               d1_busy, d1_ce);
    end
    n_compared++;
    if ({d3_a_gnt, d3_a_done, d3_a_rdata, d3_b_gnt, d3_b_done, d3_b_rdata,
         d3_ce, d3_rd, d3_wr, d3_addr, d3_dwr, d3_busy} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs_lat3: some output nonzero (busy=%b ce=%b), required all 0",
               d3_busy, d3_ce);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_a_read();
    apply_reset();
    a_req = 1'b1; a_addr = 32'h100; ram_rd_data = 32'hDEADBEEF;
    tick();
    n_compared++;
    if ({d1_a_gnt, d1_ce, d1_rd, d1_wr} !== 4'b1110) begin
      n_mismatched++;
      $display("[TB] FAIL a_read_access: gnt/ce/rd/wr=%b, required 1110",
               {d1_a_gnt, d1_ce, d1_rd, d1_wr});
    end
    n_compared++;
    if (d1_addr !== 32'h100) begin
      n_mismatched++;
      $display("[TB] FAIL a_read_addr: got %h, required 00000100", d1_addr);
    end
    a_req = 1'b0;
    tick();
    n_compared++;
    if ({d1_a_gnt, d1_a_done, d1_ce, d1_rd} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL a_read_wait: gnt/done/ce/rd=%b, required 0000",
               {d1_a_gnt, d1_a_done, d1_ce, d1_rd});
    end
    tick();
    n_compared++;
    if (d1_a_done !== 1'b1 || d1_a_rdata !== 32'hDEADBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL a_read_done: done=%b rdata=%h, required 1 deadbeef", d1_a_done, d1_a_rdata);
    end
    n_compared++;
    if (d1_b_rdata !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL a_read_b_rdata: got %h, required 00000000", d1_b_rdata);
    end
    tick();
    n_compared++;
    if ({d1_a_done, d1_busy} !== 2'b00 || d1_a_rdata !== 32'hDEADBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL a_read_after: done=%b busy=%b rdata=%h, required 0 0 deadbeef",
               d1_a_done, d1_busy, d1_a_rdata);
    end
  endtask

  task automatic test_b_store();
    logic rd_seen;
    apply_reset();
    rd_seen = 1'b0;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 32'h2000; b_wdata = 32'h12345678;
    tick();
    rd_seen |= d1_rd;
    n_compared++;
    if ({d1_b_gnt, d1_ce, d1_wr} !== 3'b111 || d1_addr !== 32'h2000 || d1_dwr !== 32'h12345678) begin
      n_mismatched++;
      $display("[TB] FAIL b_store_access: gnt/ce/wr=%b addr=%h wdata=%h, required 111 00002000 12345678",
               {d1_b_gnt, d1_ce, d1_wr}, d1_addr, d1_dwr);
    end
    b_req = 1'b0;
    tick();
    rd_seen |= d1_rd;
    n_compared++;
    if (d1_b_done !== 1'b1 || {d1_ce, d1_wr} !== 2'b00 || d1_addr !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL b_store_done: done=%b ce/wr=%b addr=%h, required 1 00 00000000",
               d1_b_done, {d1_ce, d1_wr}, d1_addr);
    end
    tick();
    rd_seen |= d1_rd;
    n_compared++;
    if ({d1_b_done, d1_busy} !== 2'b00 || d1_b_rdata !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL b_store_after: done=%b busy=%b rdata=%h, required 0 0 00000000",
               d1_b_done, d1_busy, d1_b_rdata);
    end
    n_compared++;
    if (rd_seen !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b_store_no_rd: rd seen=%b, required 0", rd_seen);
    end
  endtask

  // Both ports hold loads continuously; expected A grants are at the listed grant indices.
  // drop_a_at/raise_a_at (-1 = never) toggle A's request when that grant index is observed.
  task automatic run_grant_sequence(input string name, input int n_grants,
                                    input int a_idx0, input int a_idx1,
                                    input int drop_a_at, input int raise_a_at);
    int grants = 0;
    int cycles = 0;
    logic [1:0] exp_gnt;
    apply_reset();
    a_req = 1'b1; a_addr = 32'h40; b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h80;
    while (grants < n_grants && cycles < 200) begin
      tick();
      cycles++;
      if (d1_a_gnt || d1_b_gnt) begin
        exp_gnt = (grants == a_idx0 || grants == a_idx1) ? 2'b10 : 2'b01;
        n_compared++;
        if ({d1_a_gnt, d1_b_gnt} !== exp_gnt) begin
          n_mismatched++;
          $display("[TB] FAIL %s_grant%0d: a/b gnt=%b, required %b", name, grants,
                   {d1_a_gnt, d1_b_gnt}, exp_gnt);
        end
        if (grants == drop_a_at)  a_req = 1'b0;
        if (grants == raise_a_at) a_req = 1'b1;
        grants++;
      end
    end
    n_compared++;
    if (grants != n_grants) begin
      n_mismatched++;
      $display("[TB] FAIL %s_timeout: saw %0d grants, required %0d", name, grants, n_grants);
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_starvation();
    run_grant_sequence("starve", 10, 4, 9, -1, -1);
  endtask

  task automatic test_starve_clear();
    run_grant_sequence("starve_clear", 9, 8, 8, 2, 3);
  endtask

  task automatic test_rd_lat3();
    int lat;
    apply_reset();
    a_req = 1'b1; a_addr = 32'h300; ram_rd_data = 32'hCAFEF00D;
    tick();
    a_req = 1'b0;
    lat = 1;
    while (d3_a_done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_compared++;
    if (lat != 5 || d3_a_rdata !== 32'hCAFEF00D) begin
      n_mismatched++;
      $display("[TB] FAIL lat3_a_load: done after %0d cycles rdata=%h, required 5 cafef00d", lat, d3_a_rdata);
    end
    tick();
    b_req = 1'b1; b_wr = 1'b0; b_addr = 32'h3000; ram_rd_data = 32'h0BAD0000;
    tick();
    n_compared++;
    if ({d3_b_gnt, d3_rd, d3_ce} !== 3'b111 || d3_addr !== 32'h3000) begin
      n_mismatched++;
      $display("[TB] FAIL lat3_b_access: gnt/rd/ce=%b addr=%h, required 111 00003000",
               {d3_b_gnt, d3_rd, d3_ce}, d3_addr);
    end
    b_req = 1'b0; ram_rd_data = 32'h0BAD0001;
    tick(); ram_rd_data = 32'h11111111;
    tick(); ram_rd_data = 32'h22222222;
    tick(); ram_rd_data = 32'h33333333;
    n_compared++;
    if (d3_b_done !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL lat3_b_early_done: done=%b, required 0", d3_b_done);
    end
    tick(); ram_rd_data = 32'h44444444;
    n_compared++;
    if (d3_b_done !== 1'b1 || d3_b_rdata !== 32'h33333333) begin
      n_mismatched++;
      $display("[TB] FAIL lat3_b_done: done=%b rdata=%h, required 1 33333333", d3_b_done, d3_b_rdata);
    end
    n_compared++;
    if (d3_a_rdata !== 32'hCAFEF00D) begin
      n_mismatched++;
      $display("[TB] FAIL lat3_a_rdata_kept: got %h, required cafef00d", d3_a_rdata);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic done_seen;
    int lat;
    apply_reset();
    a_req = 1'b1; a_addr = 32'h500; ram_rd_data = 32'hCAFEF00D;
    tick();
    a_req = 1'b0;
    repeat (4) tick();
    n_compared++;
    if (d3_a_done !== 1'b1 || d3_a_rdata !== 32'hCAFEF00D) begin
      n_mismatched++;
      $display("[TB] FAIL rst_pre_load: done=%b rdata=%h, required 1 cafef00d", d3_a_done, d3_a_rdata);
    end
    tick();
    a_req = 1'b1; ram_rd_data = 32'hBADBADBA;
    tick();
    a_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_compared++;
    if ({d3_a_gnt, d3_a_done, d3_a_rdata, d3_ce, d3_rd, d3_wr, d3_busy} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_wait: busy=%b done=%b rdata=%h, required 0 0 00000000",
               d3_busy, d3_a_done, d3_a_rdata);
    end
    done_seen = 1'b0;
    repeat (3) begin
      tick();
      done_seen |= d3_a_done | d3_b_done | d3_a_gnt;
    end
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      done_seen |= d3_a_done | d3_b_done | d3_a_gnt | d3_busy;
    end
    n_compared++;
    if (done_seen !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_no_done: activity seen=%b, required 0", done_seen);
    end
    a_req = 1'b1; a_addr = 32'h600; ram_rd_data = 32'h600DF00D;
    tick();
    a_req = 1'b0;
    lat = 1;
    while (d3_a_done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_compared++;
    if (lat != 5 || d3_a_rdata !== 32'h600DF00D) begin
      n_mismatched++;
      $display("[TB] FAIL rst_recover: done after %0d cycles rdata=%h, required 5 600df00d", lat, d3_a_rdata);
    end
  endtask

  task automatic test_idle();
    logic active;
    apply_reset();
    active = 1'b0;
    repeat (20) begin
      tick();
      active |= d1_ce | d1_rd | d1_wr | d1_busy | d3_ce | d3_rd | d3_wr | d3_busy;
    end
    n_compared++;
    if (active !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_quiet: activity=%b, required 0", active);
    end
    a_req = 1'b1; b_req = 1'b1; b_wr = 1'b0;
    tick();
    n_compared++;
    if ({d1_a_gnt, d1_b_gnt} !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL idle_then_both: a/b gnt=%b, required 01", {d1_a_gnt, d1_b_gnt});
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_a_read();
    test_b_store();
    test_starvation();
    test_starve_clear();
    test_rd_lat3();
    test_reset_mid_wait();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
